sub_layer_iter: RTL and testbench

SUB_LAYER_ITER -- requirements
Module: sub_layer_iter

---
 rtl/sub_layer_iter.sv | 150 +++++++++++++++
 tb/tb_sub_layer_iter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sub_layer_iter.sv
// rtl/sub_layer_iter.sv - iterative Ascon substitution layer, SLICES columns per cycle
//
// Purpose: accepts a 320-bit Ascon state (x0..x4), applies the 5-bit S-box to all
// 64 bit-columns over 64/SLICES cycles, then presents the result on sl0..sl4
// with a valid/ready hand-off.
//
// Ports:
//   clk        in   1   rising-edge clock
//   rst_n      in   1   asynchronous active-low reset
//   in_valid   in   1   x0..x4 valid
//   in_ready   out  1   block idle and able to accept a state
//   x0..x4     in   64  input state words (x0 is the column MSB)
//   out_valid  out  1   sl0..sl4 hold the substituted state
//   out_ready  in   1   consumer takes the result
//   sl0..sl4   out  64  substituted state words
//   busy       out  1   processing or holding a result

module sub_layer_iter #(
    parameter int SLICES   = 8,
    parameter int OUT_HOLD = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] x0,
    input  logic [63:0] x1,
    input  logic [63:0] x2,
    input  logic [63:0] x3,
    input  logic [63:0] x4,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] sl0,
    output logic [63:0] sl1,
    output logic [63:0] sl2,
    output logic [63:0] sl3,
    output logic [63:0] sl4,
    output logic        busy
);

    localparam bit SLICES_OK = (SLICES == 1) || (SLICES == 2) || (SLICES == 4) ||
                               (SLICES == 8) || (SLICES == 16) || (SLICES == 32) ||
                               (SLICES == 64);

    if (!SLICES_OK) begin : g_illegal_slices
        $error("sub_layer_iter: SLICES must be one of 1,2,4,8,16,32,64");
    end

    localparam int NSTEP = 64 / SLICES;
    localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] PROC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [4:0][63:0] work;   // work[0] = x0 row ... work[4] = x4 row
    logic [4:0][63:0] nxt;
    logic             last;

    function automatic logic [4:0] sbox(input logic [4:0] v);
        logic [4:0] r;
        case (v)
            5'h00: r = 5'h04;  5'h01: r = 5'h0B;  5'h02: r = 5'h1F;  5'h03: r = 5'h14;
            5'h04: r = 5'h1A;  5'h05: r = 5'h15;  5'h06: r = 5'h09;  5'h07: r = 5'h02;
            5'h08: r = 5'h1B;  5'h09: r = 5'h05;  5'h0A: r = 5'h08;  5'h0B: r = 5'h12;
            5'h0C: r = 5'h1D;  5'h0D: r = 5'h03;  5'h0E: r = 5'h06;  5'h0F: r = 5'h1C;
            5'h10: r = 5'h1E;  5'h11: r = 5'h13;  5'h12: r = 5'h07;  5'h13: r = 5'h0E;
            5'h14: r = 5'h00;  5'h15: r = 5'h0D;  5'h16: r = 5'h11;  5'h17: r = 5'h18;
            5'h18: r = 5'h10;  5'h19: r = 5'h0C;  5'h1A: r = 5'h01;  5'h1B: r = 5'h19;
            5'h1C: r = 5'h16;  5'h1D: r = 5'h0A;  5'h1E: r = 5'h0F;  default: r = 5'h17;
        endcase
        return r;
    endfunction

    // Substitute the current window of SLICES columns; everything else passes through.
    always_comb begin
        nxt = work;
        for (int j = 0; j < SLICES; j++) begin
            logic [5:0] idx;
            logic [4:0] sub;
            idx = 6'(int'(cnt) * SLICES + j);
            sub = sbox({work[0][idx], work[1][idx], work[2][idx], work[3][idx], work[4][idx]});
            nxt[0][idx] = sub[4];
            nxt[1][idx] = sub[3];
            nxt[2][idx] = sub[2];
            nxt[3][idx] = sub[1];
            nxt[4][idx] = sub[0];
        end
    end

    assign last = (cnt == CW'(NSTEP - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            work  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work  <= {x4, x3, x2, x1, x0};
                        cnt   <= '0;
                        state <= PROC;
                    end
                end
                PROC: begin
                    work <= nxt;
                    cnt  <= cnt + CW'(1);
                    if (last) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    // Going back to IDLE (not straight to a new accept) keeps the
                    // hand-off and the next capture in separate cycles.
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == PROC) || (state == DONE);

    if (OUT_HOLD != 0) begin : g_hold
        // Result register loaded with the final substitution step; it cannot move
        // until the next operation finishes, so it stays frozen under backpressure.
        logic [4:0][63:0] hold;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                hold <= '0;
            end else if ((state == PROC) && last) begin
                hold <= nxt;
            end
        end

        assign {sl4, sl3, sl2, sl1, sl0} = hold;
    end else begin : g_pass
        assign {sl4, sl3, sl2, sl1, sl0} = work;
    end

endmodule

// File: tb/tb_sub_layer_iter.sv
// tb/tb_sub_layer_iter.sv - self-checking bench for sub_layer_iter across all SLICES values

module tb_sub_layer_iter;

    localparam int NDUT = 8;
    localparam logic [63:0] ON = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] ZZ = 64'h0;
    localparam logic [63:0] PP = 64'hF0F0_F0F0_F0F0_F0F0;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [63:0] x [5];
    logic        iv  [NDUT];
    logic        orr [NDUT];
    logic        ir  [NDUT];
    logic        ov  [NDUT];
    logic        bz  [NDUT];
    logic [63:0] so  [NDUT][5];

    // Instances 0..6: SLICES = 1,2,4,...,64 with held outputs; instance 7: SLICES=8, unregistered outputs.
    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        sub_layer_iter #(
            .SLICES   ((g == 7) ? 8 : (1 << g)),
            .OUT_HOLD ((g == 7) ? 0 : 1)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (iv[g]),
            .in_ready  (ir[g]),
            .x0        (x[0]),
            .x1        (x[1]),
            .x2        (x[2]),
            .x3        (x[3]),
            .x4        (x[4]),
            .out_valid (ov[g]),
            .out_ready (orr[g]),
            .sl0       (so[g][0]),
            .sl1       (so[g][1]),
            .sl2       (so[g][2]),
            .sl3       (so[g][3]),
            .sl4       (so[g][4]),
            .busy      (bz[g])
        );
    end

    int pass_cnt = 0;
    int total    = 0;

    logic [4:0] sbt [32];

    typedef struct {
        logic [63:0] xi [5];
        logic [63:0] ex [5];
    } vec_t;

    vec_t vt [8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic int nstep(input int k);
        return 64 / ((k == 7) ? 8 : (1 << k));
    endfunction

    task automatic model(input logic [63:0] a [5], output logic [63:0] e [5]);
        for (int w = 0; w < 5; w++) e[w] = '0;
        for (int i = 0; i < 64; i++) begin
            logic [4:0] c;
            logic [4:0] s;
            c = {a[0][i], a[1][i], a[2][i], a[3][i], a[4][i]};
            s = sbt[c];
            e[0][i] = s[4]; e[1][i] = s[3]; e[2][i] = s[2]; e[3][i] = s[1]; e[4][i] = s[0];
        end
    endtask

    // Call with the next clock event being a rising edge and the DUT idle.
    task automatic run_txn(input int k, input logic [63:0] a [5], input logic [63:0] e [5],
                           input string tag, input bit release_now);
        int lat;
        int busy_n;
        x = a;
        iv[k] = 1'b1;
        @(posedge clk); #1;
        iv[k]  = 1'b0;
        lat    = 1;
        busy_n = bz[k] ? 1 : 0;
        while (!ov[k] && lat < 200) begin
            @(posedge clk); #1;
            lat++;
            if (bz[k]) busy_n++;
        end
        check({tag, " latency"}, 64'(lat), 64'(nstep(k) + 1));
        check({tag, " busy cycles"}, 64'(busy_n), 64'(nstep(k) + 1));
        for (int w = 0; w < 5; w++) check($sformatf("%s sl%0d", tag, w), so[k][w], e[w]);
        if (release_now) begin
            orr[k] = 1'b1;
            @(posedge clk); #1;
            orr[k] = 1'b0;
            check({tag, " idle after handoff"}, {61'd0, ir[k], ov[k], bz[k]}, 64'b100);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] a [5];
        logic [63:0] e [5];

        sbt = '{5'h04, 5'h0B, 5'h1F, 5'h14, 5'h1A, 5'h15, 5'h09, 5'h02,
                5'h1B, 5'h05, 5'h08, 5'h12, 5'h1D, 5'h03, 5'h06, 5'h1C,
                5'h1E, 5'h13, 5'h07, 5'h0E, 5'h00, 5'h0D, 5'h11, 5'h18,
                5'h10, 5'h0C, 5'h01, 5'h19, 5'h16, 5'h0A, 5'h0F, 5'h17};

        // Hand-computed vectors: uniform columns map to one S-box entry each.
        vt[0].xi = '{ZZ, ZZ, ZZ, ZZ, ZZ};  vt[0].ex = '{ZZ, ZZ, ON, ZZ, ZZ};  // 00->04
        vt[1].xi = '{ON, ON, ON, ON, ON};  vt[1].ex = '{ON, ZZ, ON, ON, ON};  // 1F->17
        vt[2].xi = '{ON, ZZ, ZZ, ZZ, ZZ};  vt[2].ex = '{ON, ON, ON, ON, ZZ};  // 10->1E
        vt[3].xi = '{ZZ, ZZ, ZZ, ZZ, ON};  vt[3].ex = '{ZZ, ON, ZZ, ON, ON};  // 01->0B
        vt[4].xi = '{ZZ, ON, ZZ, ZZ, ZZ};  vt[4].ex = '{ON, ON, ZZ, ON, ON};  // 08->1B
        vt[5].xi = '{PP, ZZ, ZZ, ZZ, ZZ};  vt[5].ex = '{PP, PP, ON, PP, ZZ};  // 10/00 mix
        vt[6].xi = '{ZZ, ZZ, ON, ZZ, ZZ};  vt[6].ex = '{ON, ON, ZZ, ON, ZZ};  // 04->1A
        vt[7].xi = '{PP, ~PP, ZZ, ZZ, ZZ}; vt[7].ex = '{ON, ON, PP, ON, ~PP}; // 10/08 mix

        for (int k = 0; k < NDUT; k++) begin
            iv[k]  = 1'b0;
            orr[k] = 1'b0;
        end
        for (int w = 0; w < 5; w++) x[w] = '0;

        // Reset state
        #2;
        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("reset flags dut%0d", k), {61'd0, ir[k], ov[k], bz[k]}, 64'b100);
            check($sformatf("reset sl dut%0d", k),
                  so[k][0] | so[k][1] | so[k][2] | so[k][3] | so[k][4], ZZ);
        end

        // First accept on the first rising edge after release (via vector 0).
        @(negedge clk);
        rst_n = 1'b1;
        for (int v = 0; v < 8; v++) run_txn(3, vt[v].xi, vt[v].ex, $sformatf("vec%0d", v), 1'b1);

        // Corner vectors on the widest and narrowest configurations.
        run_txn(6, vt[1].xi, vt[1].ex, "s64 ones", 1'b1);
        run_txn(0, vt[2].xi, vt[2].ex, "s1 x0ones", 1'b1);

        // Random states through every configuration against the table model.
        for (int k = 0; k < NDUT; k++) begin
            for (int w = 0; w < 5; w++) a[w] = {$urandom(), $urandom()};
            model(a, e);
            run_txn(k, a, e, $sformatf("rand dut%0d", k), 1'b1);
        end

        // Backpressure: hold the result, wiggle the input side, nothing may move.
        for (int w = 0; w < 5; w++) a[w] = {$urandom(), $urandom()};
        model(a, e);
        run_txn(3, a, e, "bp", 1'b0);
        for (int c = 0; c < 10; c++) begin
            logic ok;
            iv[3] = ~iv[3];
            for (int w = 0; w < 5; w++) x[w] = {$urandom(), $urandom()};
            @(posedge clk); #1;
            ok = ov[3] && !ir[3];
            for (int w = 0; w < 5; w++) ok = ok && (so[3][w] === e[w]);
            check($sformatf("bp hold cycle %0d", c), 64'(ok), 64'd1);
        end
        iv[3]  = 1'b0;
        orr[3] = 1'b1;
        @(posedge clk); #1;
        orr[3] = 1'b0;
        check("bp release", {61'd0, ir[3], ov[3], bz[3]}, 64'b100);
        @(posedge clk); #1;
        check("bp no capture", {62'd0, ir[3], bz[3]}, 64'b10);

        // Back-to-back period with in_valid and out_ready held high.
        for (int k = 0; k < 7; k++) begin
            int cyc;
            int acc0;
            int acc1;
            int naccept;
            logic prev_ir;
            cyc = 0; acc0 = 0; acc1 = 0; naccept = 0;
            iv[k]  = 1'b1;
            orr[k] = 1'b1;
            prev_ir = ir[k];
            while (naccept < 2 && cyc < 300) begin
                @(posedge clk); #1;
                cyc++;
                if (prev_ir) begin
                    if (naccept == 0) acc0 = cyc;
                    else acc1 = cyc;
                    naccept++;
                end
                if (naccept == 2) iv[k] = 1'b0;
                prev_ir = ir[k];
            end
            check($sformatf("b2b period dut%0d", k), 64'(acc1 - acc0), 64'(nstep(k) + 2));
            iv[k] = 1'b0;
            cyc = 0;
            while (!ir[k] && cyc < 300) begin
                @(posedge clk); #1;
                cyc++;
            end
            orr[k] = 1'b0;
            check($sformatf("b2b drain dut%0d", k), 64'(ir[k]), 64'd1);
        end

        // Reset in the middle of PROC aborts immediately.
        for (int w = 0; w < 5; w++) x[w] = {$urandom(), $urandom()};
        iv[3] = 1'b1;
        @(posedge clk); #1;
        iv[3] = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        for (int k = 3; k < NDUT; k += 4) begin
            check($sformatf("midreset flags dut%0d", k), {61'd0, ir[k], ov[k], bz[k]}, 64'b100);
            check($sformatf("midreset sl dut%0d", k),
                  so[k][0] | so[k][1] | so[k][2] | so[k][3] | so[k][4], ZZ);
        end
        @(negedge clk);
        rst_n = 1'b1;
        begin
            int seen;
            seen = 0;
            repeat (12) begin
                @(posedge clk); #1;
                if (ov[3] || bz[3]) seen++;
            end
            check("no result after reset", 64'(seen), 64'd0);
        end
        for (int w = 0; w < 5; w++) a[w] = {$urandom(), $urandom()};
        model(a, e);
        run_txn(3, a, e, "post reset", 1'b1);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
